// File: rtl/alu_sequencer.sv
// Single-issue RV32I OP/OP-IMM execute controller: decode, operand fetch, ALU issue, writeback.
// Define ALU_SEQ_SHIFT_TRAP_EN to reject all shift instructions as illegal.
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_rd,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef struct packed {
    logic        ill;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } dec_t;

  state_t state, state_nxt;
  dec_t   dec;

  logic [31:1][31:0] rf;
  logic [4:0]        rd_q;
  logic              ill_q;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2;
  logic        is_op, is_imm;
  logic [31:0] rs1_val, rs2_val;

  assign opc    = instr[6:0];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];
  assign is_op  = (opc == 7'b0110011);
  assign is_imm = (opc == 7'b0010011);

  // x0 has no storage; reads of index 0 are forced to zero
  assign rs1_val  = (rs1 == 5'd0)      ? 32'd0 : rf[rs1];
  assign rs2_val  = (rs2 == 5'd0)      ? 32'd0 : rf[rs2];
  assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  always_comb begin
    dec     = '0;
    dec.a   = rs1_val;
    if (is_op) begin
      dec.op  = {f7[5], f3};
      dec.b   = rs2_val;
      if (f7 != 7'b0000000 && f7 != 7'b0100000)
        dec.ill = 1'b1;
      else if (f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
        dec.ill = 1'b1;
    end else if (is_imm) begin
      dec.op  = (f3 == 3'b101) ? {instr[30], f3} : {1'b0, f3};
      dec.b   = {{20{instr[31]}}, instr[31:20]};
      if (f3 == 3'b001 && f7 != 7'b0000000)
        dec.ill = 1'b1;
      if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000)
        dec.ill = 1'b1;
    end else begin
      dec.ill = 1'b1;
    end
`ifdef ALU_SEQ_SHIFT_TRAP_EN
    if ((is_op || is_imm) && (f3 == 3'b001 || f3 == 3'b101))
      dec.ill = 1'b1;
`endif
    // Rejected instructions present an all-zero ADD to the ALU
    if (dec.ill) begin
      dec.op = 4'd0;
      dec.a  = 32'd0;
      dec.b  = 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_rs1 <= '0;
      alu_rs2 <= '0;
      alu_op  <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      rf      <= '0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      if (state == IDLE && instr_valid) begin
        alu_rs1 <= dec.a;
        alu_rs2 <= dec.b;
        alu_op  <= dec.op;
        rd_q    <= instr[11:7];
        ill_q   <= dec.ill;
      end
      // Flags are registered at the EXEC edge so they are high exactly in WB
      if (state == EXEC) begin
        done    <= 1'b1;
        illegal <= ill_q;
      end
      if (state == WB && !ill_q && rd_q != 5'd0)
        rf[rd_q] <= alu_rd;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a registered reference ALU on the alu_rd return path.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] alu_rs1, alu_rs2, alu_rd;
  logic [3:0]  alu_op;
  logic        done, illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exec_rs1, exec_rs2;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_op(alu_op), .alu_rd(alu_rd), .done(done), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Reference ALU; unmodelled ops (shifts) return a marker so a write is visible
  always @(posedge clk) begin
    case (alu_op)
      4'b0000: alu_rd <= alu_rs1 + alu_rs2;
      4'b1000: alu_rd <= alu_rs1 - alu_rs2;
      4'b0010: alu_rd <= {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
      4'b0011: alu_rd <= {31'd0, alu_rs1 < alu_rs2};
      4'b0100: alu_rd <= alu_rs1 ^ alu_rs2;
      4'b0110: alu_rd <= alu_rs1 | alu_rs2;
      4'b0111: alu_rd <= alu_rs1 & alu_rs2;
      default: alu_rd <= 32'h5A5A0000 | {28'd0, alu_op};
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic rdreg(input logic [4:0] a, input logic [31:0] exp, input string tag);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // Issue one instruction and follow it through EXEC and WB; exp_op < 0 skips the op check
  task automatic run(input logic [31:0] ins, input logic exp_ill, input int exp_op, input string tag);
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".done_exec"}, {31'd0, done}, 32'd0);
    if (exp_op >= 0) chk({tag, ".op"}, {28'd0, alu_op}, exp_op[31:0]);
    exec_rs1 = alu_rs1;
    exec_rs2 = alu_rs2;
    @(negedge clk);
    chk({tag, ".done_wb"}, {31'd0, done}, 32'd1);
    chk({tag, ".ill_wb"}, {31'd0, illegal}, {31'd0, exp_ill});
    @(negedge clk);
    chk({tag, ".done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    dbg_addr = '0;
    #1;
    chk("rst.ready", {31'd0, instr_ready}, 32'd1);
    chk("rst.op", {28'd0, alu_op}, 32'd0);
    chk("rst.rs1", alu_rs1, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    rdreg(5'd1, 32'd0, "rst.x1");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(32'h00500093, 1'b0, 0, "addi_x1");
    rdreg(5'd1, 32'd5, "x1");
    run(32'h FFF00113, 1'b0, 0, "addi_x2");
    chk("addi_x2.rs2", exec_rs2, 32'hFFFFFFFF);
    rdreg(5'd2, 32'hFFFFFFFF, "x2");

    run(32'h402082B3, 1'b0, 8, "sub");
    chk("sub.rs1", exec_rs1, 32'd5);
    rdreg(5'd5, 32'd6, "x5");
    run(32'h0020A1B3, 1'b0, 2, "slt");
    rdreg(5'd3, 32'd0, "x3");
    run(32'h0020B233, 1'b0, 3, "sltu");
    rdreg(5'd4, 32'd1, "x4");

    run(32'h00700013, 1'b0, 0, "addi_x0");
    rdreg(5'd0, 32'd0, "x0");

    run(32'h00000073, 1'b1, 0, "sys_ill");
    chk("sys_ill.rs1", exec_rs1, 32'd0);
    chk("sys_ill.rs2", exec_rs2, 32'd0);
    run(32'h022083B3, 1'b1, 0, "mul_ill");
    run(32'h4020A3B3, 1'b1, 0, "f7slt_ill");
    rdreg(5'd1, 32'd5, "keep.x1");
    rdreg(5'd2, 32'hFFFFFFFF, "keep.x2");
    rdreg(5'd3, 32'd0, "keep.x3");
    rdreg(5'd4, 32'd1, "keep.x4");
    rdreg(5'd5, 32'd6, "keep.x5");
    rdreg(5'd7, 32'd0, "keep.x7");

`ifdef ALU_SEQ_SHIFT_TRAP_EN
    run(32'h00109313, 1'b1, 0, "slli_trap");
    rdreg(5'd6, 32'd0, "x6");
`else
    run(32'h00109313, 1'b0, 1, "slli");
    rdreg(5'd6, 32'h5A5A0001, "x6");
`endif

    // Streaming ADDI x7,x7,1 with valid held: accepts every third edge
    @(negedge clk);
    instr = 32'h00138393;
    instr_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("b2b.ready%0d", k), {31'd0, instr_ready}, (k % 3 == 0) ? 32'd1 : 32'd0);
    end
    instr_valid = 1'b0;
    @(negedge clk);
    rdreg(5'd7, 32'd3, "b2b.x7");

    // Reset while an instruction sits in EXEC
    @(negedge clk);
    instr = 32'h00900413;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstx.ready", {31'd0, instr_ready}, 32'd1);
    chk("rstx.op", {28'd0, alu_op}, 32'd0);
    chk("rstx.rs1", alu_rs1, 32'd0);
    chk("rstx.rs2", alu_rs2, 32'd0);
    rdreg(5'd1, 32'd0, "rstx.x1");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rstx.done", {31'd0, done}, 32'd0);
    end
    rdreg(5'd8, 32'd0, "rstx.x8");
    chk("rstx.ready2", {31'd0, instr_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
